// File: rtl/alu_ctrl_mc_if.sv
// Decode/stall handshake between the main-control stage and the ALU control
// block. The slave side is the ALU control; the master side is the pipeline.
interface alu_ctrl_mc_if #(
   parameter int OP_W        = 3,
   parameter int CTRL_W      = 4,
   parameter int STALL_CNT_W = 16
);
   logic                   valid_i;
   logic                   kill_i;
   logic [5:0]             funct_i;
   logic [OP_W-1:0]        ALUOp_i;
   logic [CTRL_W-1:0]      ALUCtrl_o;
   logic                   shamt_select_o;
   logic                   jump_select_o;
   logic                   busy_o;
   logic                   done_o;
   logic                   illegal_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   modport slave (
      input  valid_i, kill_i, funct_i, ALUOp_i,
      output ALUCtrl_o, shamt_select_o, jump_select_o,
             busy_o, done_o, illegal_o, stall_cnt_o
   );

   modport master (
      output valid_i, kill_i, funct_i, ALUOp_i,
      input  ALUCtrl_o, shamt_select_o, jump_select_o,
             busy_o, done_o, illegal_o, stall_cnt_o
   );
endinterface

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with multi-cycle mul/div sequencing. Single-cycle ops
// decode combinationally; mul/div latch their funct and hold the pipeline for
// N-1 cycles, signalling done in the final cycle. A saturating counter tracks
// the number of stalled cycles.
module alu_ctrl_mc #(
   parameter int OP_W        = 3,
   parameter int CTRL_W      = 4,
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 8,
   parameter int STALL_CNT_W = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   alu_ctrl_mc_if.slave bus
);

   localparam logic [5:0] F_SLL  = 6'd3;
   localparam logic [5:0] F_SRAV = 6'd7;
   localparam logic [5:0] F_JR   = 6'd8;
   localparam logic [5:0] F_MUL  = 6'd24;
   localparam logic [5:0] F_DIV  = 6'd26;
   localparam logic [5:0] F_ADD  = 6'd32;
   localparam logic [5:0] F_SUB  = 6'd34;
   localparam logic [5:0] F_AND  = 6'd36;
   localparam logic [5:0] F_OR   = 6'd37;
   localparam logic [5:0] F_SLT  = 6'd42;

   // The counter is loaded with N-2: the accept cycle and the done cycle are
   // both part of the op, leaving N-2 intermediate EXEC cycles.
   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 2);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       shamt;
      logic       jump;
      logic       illegal;
   } dec_t;

   state_t                 state_q;
   logic [7:0]             cnt_q;
   logic [5:0]             funct_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   logic accept;
   logic exec_active;
   logic busy;
   dec_t dec_in;
   dec_t dec_lat;
   dec_t dec;

   // Maps (ALUOp, funct) to the 4-bit ALU select and the operand/jump muxes.
   function automatic dec_t decode(input logic [OP_W-1:0] op, input logic [5:0] f);
      dec_t d;
      d.ctrl    = 4'b1111;
      d.shamt   = 1'b0;
      d.jump    = 1'b1;
      d.illegal = 1'b0;
      if (op == '0) begin
         case (f)
            F_SLL:   begin d.ctrl = 4'b1000; d.shamt = 1'b1; end
            F_SRAV:  d.ctrl = 4'b1001;
            F_JR:    begin d.ctrl = 4'b0010; d.jump = 1'b0; end
            F_MUL:   d.ctrl = 4'b0101;
            F_DIV:   d.ctrl = 4'b1101;
            F_ADD:   d.ctrl = 4'b0010;
            F_SUB:   d.ctrl = 4'b0110;
            F_AND:   d.ctrl = 4'b0000;
            F_OR:    d.ctrl = 4'b0001;
            F_SLT:   d.ctrl = 4'b0100;
            default: d.illegal = 1'b1;
         endcase
      end else begin
         case (op)
            OP_W'(1): d.ctrl = 4'b0111;
            OP_W'(2): d.ctrl = 4'b1010;
            OP_W'(3): d.ctrl = 4'b0010;
            OP_W'(4): d.ctrl = 4'b0011;
            OP_W'(5): d.ctrl = 4'b0001;
            OP_W'(6): d.ctrl = 4'b1011;
            OP_W'(7): d.ctrl = 4'b1100;
            default:  d.ctrl = 4'b1111;
         endcase
      end
      return d;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      if (&v) return v;
      else    return v + 1'b1;
   endfunction

   // Accept, stall and decode-source selection.
   always_comb begin
      accept      = (state_q == S_IDLE) && bus.valid_i && !bus.kill_i &&
                    (bus.ALUOp_i == '0) &&
                    ((bus.funct_i == F_MUL) || (bus.funct_i == F_DIV));
      exec_active = (state_q == S_EXEC) && !rst_i;
      busy        = !rst_i && (accept ||
                    ((state_q == S_EXEC) && (cnt_q != 8'd0) && !bus.kill_i));
      dec_in      = decode(bus.ALUOp_i, bus.funct_i);
      dec_lat     = decode('0, funct_q);
      dec         = exec_active ? dec_lat : dec_in;
   end

   // Next value of the saturating stall counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (busy) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   // Stall counter register; cleared by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   // IDLE/EXEC sequencer with the cycle down-counter and latched funct.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         funct_q <= 6'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  funct_q <= bus.funct_i;
                  cnt_q   <= (bus.funct_i == F_MUL) ? MUL_LOAD : DIV_LOAD;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.kill_i) begin
                  cnt_q   <= 8'd0;
                  state_q <= S_IDLE;
               end else if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ALUCtrl_o      = CTRL_W'(dec.ctrl);
   assign bus.shamt_select_o = dec.shamt;
   assign bus.jump_select_o  = dec.jump;
   assign bus.busy_o         = busy;
   assign bus.done_o         = exec_active && (cnt_q == 8'd0) && !bus.kill_i;
   assign bus.illegal_o      = !rst_i && (state_q == S_IDLE) && bus.valid_i &&
                               dec_in.illegal;
   assign bus.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Bench for alu_ctrl_mc: table sweep of the decoder, scoreboarded multi-cycle
// sequences, and a narrow-counter instance for stall saturation.
module tb_alu_ctrl_mc;

   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_MUL = 4'b0101;
   localparam logic [3:0] C_DIV = 4'b1101;
   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_ILL = 4'b1111;

   typedef struct {
      logic [3:0]  ctrl;
      logic        shamt;
      logic        jump;
      logic        illegal;
      logic        busy;
      logic        done;
      logic        chk_stall;
      logic [15:0] stall;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic [5:0] f;
      logic       v;
      logic [3:0] ctrl;
      logic       shamt;
      logic       jump;
      logic       illegal;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t tbl[$];

   alu_ctrl_mc_if #(.OP_W(3), .CTRL_W(4), .STALL_CNT_W(16)) bus ();
   alu_ctrl_mc_if #(.OP_W(3), .CTRL_W(4), .STALL_CNT_W(4))  bus2 ();

   alu_ctrl_mc #(.OP_W(3), .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .STALL_CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   alu_ctrl_mc #(.OP_W(3), .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .STALL_CNT_W(4)) dut2 (
      .clk_i(clk), .rst_i(rst2), .bus(bus2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [3:0] c, input logic sh, input logic j,
                               input logic il, input logic b, input logic d,
                               input logic cs, input logic [15:0] s);
      exp_t e;
      e.ctrl = c; e.shamt = sh; e.jump = j; e.illegal = il;
      e.busy = b; e.done = d; e.chk_stall = cs; e.stall = s;
      return e;
   endfunction

   // Reference funct table for ALUOp = 0: returns {legal, ctrl}.
   function automatic logic [4:0] ref_funct(input logic [5:0] f);
      case (f)
         6'd3:    return {1'b1, 4'b1000};
         6'd7:    return {1'b1, 4'b1001};
         6'd8:    return {1'b1, 4'b0010};
         6'd24:   return {1'b1, 4'b0101};
         6'd26:   return {1'b1, 4'b1101};
         6'd32:   return {1'b1, 4'b0010};
         6'd34:   return {1'b1, 4'b0110};
         6'd36:   return {1'b1, 4'b0000};
         6'd37:   return {1'b1, 4'b0001};
         6'd42:   return {1'b1, 4'b0100};
         default: return {1'b0, 4'b1111};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sbq.pop_front();
      chk({tag, ".ctrl"},    32'(bus.ALUCtrl_o),      32'(e.ctrl));
      chk({tag, ".shamt"},   32'(bus.shamt_select_o), 32'(e.shamt));
      chk({tag, ".jump"},    32'(bus.jump_select_o),  32'(e.jump));
      chk({tag, ".illegal"}, 32'(bus.illegal_o),      32'(e.illegal));
      chk({tag, ".busy"},    32'(bus.busy_o),         32'(e.busy));
      chk({tag, ".done"},    32'(bus.done_o),         32'(e.done));
      if (e.chk_stall) chk({tag, ".stall"}, 32'(bus.stall_cnt_o), 32'(e.stall));
   endtask

   // One cycle: drive after the rising edge, compare at the falling edge.
   task automatic step(input string tag, input logic v, input logic k, input logic r,
                       input logic [2:0] op, input logic [5:0] f, input exp_t e);
      @(posedge clk);
      #1;
      bus.valid_i = v;
      bus.kill_i  = k;
      bus.ALUOp_i = op;
      bus.funct_i = f;
      rst         = r;
      sbq.push_back(e);
      @(negedge clk);
      sb_check(tag);
   endtask

   task automatic do_reset(input string tag);
      step({tag, ".rst"}, 1'b0, 1'b0, 1'b1, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 0, 16'd0));
   endtask

   initial begin
      logic [3:0] opmap [8];
      logic [4:0] rf;
      vec_t       t;
      opmap = '{4'b1111, 4'b0111, 4'b1010, 4'b0010, 4'b0011, 4'b0001, 4'b1011, 4'b1100};

      bus.valid_i = 1'b0; bus.kill_i = 1'b0; bus.ALUOp_i = 3'd0; bus.funct_i = 6'd0;
      bus2.valid_i = 1'b0; bus2.kill_i = 1'b0; bus2.ALUOp_i = 3'd0; bus2.funct_i = 6'd0;

      // Decode vector table.
      for (int i = 1; i < 8; i++) begin
         t.op = 3'(i); t.f = 6'(i * 3); t.v = 1'b1; t.ctrl = opmap[i];
         t.shamt = 1'b0; t.jump = 1'b1; t.illegal = 1'b0;
         tbl.push_back(t);
      end
      for (int f = 0; f < 64; f++) begin
         rf = ref_funct(6'(f));
         t.op = 3'd0; t.f = 6'(f);
         t.v = !((f == 24) || (f == 26));
         t.ctrl = rf[3:0];
         t.shamt = (f == 3);
         t.jump = (f != 8);
         t.illegal = !rf[4] && t.v;
         tbl.push_back(t);
      end
      t.op = 3'd0; t.f = 6'd1; t.v = 1'b0; t.ctrl = C_ILL;
      t.shamt = 1'b0; t.jump = 1'b1; t.illegal = 1'b0;
      tbl.push_back(t);

      // Reset state: outputs follow inputs combinationally, status forced low.
      step("reset", 1'b1, 1'b0, 1'b1, 3'd0, 6'd1, mk(C_ILL, 0, 1, 0, 0, 0, 0, 16'd0));
      step("post_reset", 1'b0, 1'b0, 1'b0, 3'd0, 6'd8, mk(C_ADD, 0, 0, 0, 0, 0, 1, 16'd0));

      foreach (tbl[i]) begin
         step($sformatf("dec[op=%0d,f=%0d]", tbl[i].op, tbl[i].f), tbl[i].v, 1'b0, 1'b0,
              tbl[i].op, tbl[i].f,
              mk(tbl[i].ctrl, tbl[i].shamt, tbl[i].jump, tbl[i].illegal, 0, 0, 0, 16'd0));
      end

      // mul, 4 cycles; funct_i changes underneath it.
      do_reset("mul");
      step("mul.c0", 1, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd0));
      step("mul.c1", 1, 0, 0, 3'd0, 6'd32, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd1));
      step("mul.c2", 1, 0, 0, 3'd0, 6'd32, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd2));
      step("mul.c3", 1, 0, 0, 3'd0, 6'd32, mk(C_MUL, 0, 1, 0, 0, 1, 1, 16'd3));
      step("mul.c4", 0, 0, 0, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 1, 16'd3));

      // div immediately followed by mul.
      do_reset("dm");
      step("dm.c0", 1, 0, 0, 3'd0, 6'd26, mk(C_DIV, 0, 1, 0, 1, 0, 1, 16'd0));
      for (int c = 1; c < 7; c++)
         step($sformatf("dm.c%0d", c), 1, 0, 0, 3'd0, 6'd24,
              mk(C_DIV, 0, 1, 0, 1, 0, 1, 16'(c)));
      step("dm.c7",  1, 0, 0, 3'd0, 6'd24, mk(C_DIV, 0, 1, 0, 0, 1, 1, 16'd7));
      step("dm.c8",  1, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd7));
      step("dm.c9",  1, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd8));
      step("dm.c10", 1, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd9));
      step("dm.c11", 0, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 0, 1, 1, 16'd10));
      step("dm.c12", 0, 0, 0, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 1, 16'd10));

      // kill during a div.
      do_reset("kill");
      step("kill.c0", 1, 0, 0, 3'd0, 6'd26, mk(C_DIV, 0, 1, 0, 1, 0, 1, 16'd0));
      step("kill.c1", 0, 0, 0, 3'd0, 6'd32, mk(C_DIV, 0, 1, 0, 1, 0, 1, 16'd1));
      step("kill.c2", 1, 1, 0, 3'd0, 6'd24, mk(C_DIV, 0, 1, 0, 0, 0, 1, 16'd2));
      step("kill.c3", 1, 0, 0, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 1, 16'd2));
      step("kill.c4", 0, 0, 0, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 1, 16'd2));

      // reset during a mul.
      do_reset("rmul");
      step("rmul.c0", 1, 0, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 1, 0, 1, 16'd0));
      step("rmul.c1", 1, 1, 1, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 0, 0, 0, 16'd0));
      step("rmul.c2", 0, 0, 0, 3'd0, 6'd36, mk(C_AND, 0, 1, 0, 0, 0, 1, 16'd0));
      step("rmul.c3", 0, 0, 0, 3'd0, 6'd36, mk(C_AND, 0, 1, 0, 0, 0, 1, 16'd0));
      step("rmul.c4", 0, 0, 0, 3'd0, 6'd36, mk(C_AND, 0, 1, 0, 0, 0, 1, 16'd0));

      // kill in IDLE blocks acceptance.
      step("ikill.c0", 1, 1, 0, 3'd0, 6'd24, mk(C_MUL, 0, 1, 0, 0, 0, 1, 16'd0));
      step("ikill.c1", 0, 0, 0, 3'd0, 6'd32, mk(C_ADD, 0, 1, 0, 0, 0, 1, 16'd0));

      // Stall counter saturation on the 4-bit instance: repeated divs.
      @(posedge clk);
      #1;
      rst2 = 1'b1;
      @(posedge clk);
      #1;
      rst2 = 1'b0;
      bus2.valid_i = 1'b1; bus2.ALUOp_i = 3'd0; bus2.funct_i = 6'd26;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c == 7) chk("sat.mid", 32'(bus2.stall_cnt_o), 32'd7);
      end
      chk("sat.full", 32'(bus2.stall_cnt_o), 32'd15);
      @(posedge clk);
      #1;
      bus2.valid_i = 1'b0;
      repeat (10) @(negedge clk);
      chk("sat.hold", 32'(bus2.stall_cnt_o), 32'd15);
      chk("sat.busy", 32'(bus2.busy_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_mc.md
ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter OP_W, 3, width of ALUOp_i.
REQ-002 The block SHALL have parameter CTRL_W, 4, width of ALUCtrl_o; CTRL_W >= 4, upper bits zero-filled.
REQ-003 The block SHALL have parameter MUL_CYCLES, 4, total cycles a mul occupies; legal range 2..255.
REQ-004 The block SHALL have parameter DIV_CYCLES, 8, total cycles a div occupies; legal range 2..255.
REQ-005 The block SHALL have parameter STALL_CNT_W, 16, width of the stall performance counter.
Ports (name, direction, width, meaning):
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: clk_i, input, 1, rising-edge clock; rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have valid_i, input, 1, an instruction is present in decode this cycle.
REQ-008 The block SHALL have kill_i, input, 1, pipeline flush; aborts any in-flight multi-cycle op.
REQ-009 The block SHALL have funct_i, input, 6, R-type funct field.
REQ-010 The block SHALL have ALUOp_i, input, OP_W, main-control ALU opcode.
REQ-011 The block SHALL have ALUCtrl_o, output, CTRL_W, ALU operation select.
REQ-012 The block SHALL have shamt_select_o, output, 1, ALU A-operand takes shamt.
REQ-013 The block SHALL have jump_select_o, output, 1, 0 = jr (PC from register), 1 = normal.
REQ-014 The block SHALL have busy_o, output, 1, stall request to PC and IF/ID.
REQ-015 The block SHALL have done_o, output, 1, final cycle of a multi-cycle op; writeback allowed.
REQ-016 The block SHALL have illegal_o, output, 1, unsupported funct with ALUOp_i = 0 and valid_i = 1.
REQ-017 The block SHALL have stall_cnt_o, output, STALL_CNT_W, saturating count of cycles with busy_o = 1.

Function
REQ-018 The block SHALL decode ALUOp_i 1..7 to 0111, 1010, 0010, 0011, 0001, 1011, 1100 respectively.
REQ-019 For ALUOp_i = 0, the block SHALL decode funct 3 to 1000, 7 to 1001, 24 (mul) to 0101, 26 (div) to 1101, 32 to 0010, 34 to 0110, 36 to 0000, 37 to 0001, 42 to 0100, and 8 (jr) to 0010.
REQ-020 For ALUOp_i = 0 with any other funct, the block SHALL drive ALUCtrl_o = 1111 and illegal_o = valid_i; illegal_o SHALL be 0 in every other case.
REQ-021 shamt_select_o SHALL be 1 only for ALUOp_i = 0 with funct 3.
REQ-022 jump_select_o SHALL be 0 only for ALUOp_i = 0 with funct 8, and 1 otherwise.
REQ-023 In IDLE, the decode outputs SHALL be combinational from the inputs, with zero latency.
REQ-024 The FSM SHALL have states IDLE and EXEC, plus a down-counter cnt of 8 bits.
REQ-025 In IDLE, when valid_i = 1, kill_i = 0 and the op is mul or div, the block SHALL accept the op: latch funct, load cnt = N-2 (N = MUL_CYCLES or DIV_CYCLES), and move to EXEC.
REQ-026 In EXEC, the decode outputs SHALL come from the latched funct, and funct_i and ALUOp_i SHALL be ignored.
REQ-027 In EXEC with cnt != 0, the block SHALL decrement cnt.
REQ-028 In EXEC with cnt = 0, the block SHALL drive done_o = 1 for exactly that cycle and return to IDLE.
REQ-029 busy_o SHALL be (IDLE and accept condition) or (EXEC and cnt != 0), so an op of N cycles stalls N-1 cycles, and busy_o = 0 in the done cycle.
REQ-030 A new valid multi-cycle op presented in the cycle after done SHALL be accepted; there is no dead cycle.
REQ-031 kill_i = 1 in EXEC SHALL return the block to IDLE at the next edge, with done_o = 0 and busy_o = 0 in that cycle.
REQ-032 kill_i = 1 in IDLE SHALL block acceptance; kill_i SHALL win over valid_i.
REQ-033 stall_cnt_o SHALL increment on every edge where busy_o = 1, and SHALL hold at its all-ones value (saturate, no wrap).
REQ-034 Single-cycle ops and jr SHALL never assert busy_o or done_o.

Reset
REQ-035 rst_i = 1 at a clock edge SHALL force IDLE, cnt = 0, latched funct = 0, and stall_cnt_o = 0, including mid-EXEC; rst_i SHALL take priority over kill_i and valid_i.
REQ-036 While rst_i = 1, busy_o, done_o and illegal_o SHALL be 0; ALUCtrl_o, shamt_select_o and jump_select_o SHALL follow combinational decode of the inputs.

Verification
REQ-037 The bench SHALL sweep all ALUOp_i 1..7 and all 64 funct values with ALUOp_i = 0, checking ALUCtrl_o, shamt_select_o, jump_select_o and illegal_o against REQ-018..022 (funct 8 -> jump_select_o = 0; funct 3 -> shamt_select_o = 1).
REQ-038 The bench SHALL present mul with MUL_CYCLES = 4 at cycle 0 and check busy_o = 1 in cycles 0..2, done_o = 1 only in cycle 3, ALUCtrl_o = 0101 throughout (funct_i changed to 32 in cycle 1), and stall_cnt_o = 3.
REQ-039 The bench SHALL present back-to-back div then mul with DIV_CYCLES = 8 and check done_o in cycle 7, the mul accepted in cycle 8, and done_o in cycle 11.
REQ-040 The bench SHALL assert kill_i in cycle 2 of a div and check done_o = 0 and busy_o = 0 in cycle 2, IDLE in cycle 3, and a new add decoded as 0010 in cycle 3.
REQ-041 The bench SHALL assert rst_i in cycle 1 of a mul and check busy_o = 0 and stall_cnt_o = 0 after the edge, with no done_o pulse.
REQ-042 The bench SHALL, with STALL_CNT_W = 4, run 20 stall cycles and check that stall_cnt_o saturates at 15.
